ftdi_tx_arbiter: RTL

//   Round-robin scheduler sharing the single USB TX AXI-stream path between N requester streams.

---
 rtl/ftdi_tx_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/ftdi_tx_arbiter.sv
// ftdi_tx_arbiter: round-robin burst scheduler sharing one TX AXI-stream path between N requesters
module ftdi_tx_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 128,
  parameter int IDLE_TO   = 16
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic [N-1:0]    i_en,
  output logic [N-1:0]    i_rdy,
  input  logic [N*DW-1:0] i_data,
  input  logic            o_rdy,
  output logic            o_en,
  output logic [DW-1:0]   o_data,
  output logic [2:0]      o_chan
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] gnt, gnt_n, last, last_n, pick;
  logic [10:0] beats, beats_n;
  logic [7:0] idle_cnt, idle_cnt_n;
  logic any, en_g, xfer, release_g;
  logic [DW-1:0] data_g;
  // scan offsets from farthest to nearest so the stream right after last wins
  always_comb begin
    pick = '0;
    any = 1'b0;
    for (int i = N; i >= 1; i--)
      for (int k = 0; k < N; k++)
        if (i_en[k] && k == (int'(last) + i) % N) begin
          pick = 3'(k);
          any = 1'b1;
        end
  end
  always_comb begin
    en_g = 1'b0;
    data_g = '0;
    for (int k = 0; k < N; k++)
      if (gnt == 3'(k)) begin
        en_g = i_en[k];
        data_g = i_data[k*DW +: DW];
      end
  end
  always_comb begin
    i_rdy = '0;
    for (int k = 0; k < N; k++) i_rdy[k] = state == GRANT && gnt == 3'(k) && o_rdy;
  end
  assign o_en   = state == GRANT && en_g;
  assign o_data = state == GRANT ? data_g : '0;
  assign o_chan = state == GRANT ? gnt : 3'd0;
  assign xfer   = o_en && o_rdy;
  assign release_g = (xfer && beats == 11'(MAX_BURST - 1)) || (!en_g && idle_cnt == 8'(IDLE_TO - 1));
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    last_n = last;
    beats_n = beats;
    idle_cnt_n = idle_cnt;
    if (state == IDLE) begin
      if (any) begin
        state_n = GRANT;
        gnt_n = pick;
        beats_n = '0;
        idle_cnt_n = '0;
      end
    end else if (release_g) begin
      state_n = IDLE;
      last_n = gnt;
    end else if (xfer) begin
      beats_n = beats + 11'd1;
      idle_cnt_n = '0;
    end else if (!en_g) begin
      idle_cnt_n = idle_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      gnt <= '0;
      last <= 3'(N - 1);
      beats <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      last <= last_n;
      beats <= beats_n;
      idle_cnt <= idle_cnt_n;
    end
endmodule
